lsu_ctrl: RTL and testbench

- Load/store unit controller between the execute stage and the data-memory bus.
- Accepts one memory op at a time and checks alignment.
- Issues a single word-aligned bus request with byte enables and lane-replicated store data, then waits for the response.
- Returns a write-back pulse carrying sign/zero-extended load data, or an exception pulse carrying cause and faulting address.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_ctrl_if.sv | 44 ++++
 rtl/lsu_store_align.sv | 33 +++
 rtl/lsu_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and exception cause codes for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Encoding 11 has no size of its own and behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side, data-bus and write-back/exception signals of the LSU controller.
interface lsu_ctrl_if;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [1:0]  ex_size_i;
    logic        ex_unsigned_i;
    logic [4:0]  ex_rd_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] exc_tval_o;
    logic        busy_o;

    modport slave (
        input  ex_valid_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_size_i, ex_unsigned_i, ex_rd_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output ex_ready_o, data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
               wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_tval_o,
               busy_o
    );

    modport master (
        output ex_valid_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_size_i, ex_unsigned_i, ex_rd_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  ex_ready_o, data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
               wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_tval_o,
               busy_o
    );
endinterface

// File: rtl/lsu_store_align.sv
// Byte enables, lane-replicated store data and alignment check for one access.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misalign
);

    always_comb begin
        be        = 4'b1111;
        lane_data = wdata;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-bus access at a time.
// Build option LSU_TIMEOUT_EN adds a bus-wait timeout of TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | ready for an op; misaligned ops go straight to RESP
// REQ   | bus request held until granted
// WAIT  | granted, waiting for the response
// RESP  | one-cycle write-back or exception pulse
module lsu_ctrl
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input logic       clk_i,
    input logic       rst_i,
    lsu_ctrl_if.slave bus
);

    lsu_state_e  state_q, state_d;
    logic        op_we_q, op_we_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    size_e       op_size_q, op_size_d;
    logic        op_uns_q, op_uns_d;
    logic [4:0]  op_rd_q, op_rd_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_exc_q, res_exc_d;
    logic [3:0]  res_cause_q, res_cause_d;

    logic        idle;
    logic [1:0]  al_addr;
    size_e       al_size;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_lane;
    logic        al_misalign;
    logic        tmo_hit;

    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_data;

    // In IDLE the aligner checks the offered op; afterwards it drives the bus from the captured op.
    assign idle     = (state_q == IDLE);
    assign al_addr  = idle ? bus.ex_addr_i[1:0] : op_addr_q[1:0];
    assign al_size  = idle ? decode_size(bus.ex_size_i) : op_size_q;
    assign al_wdata = idle ? bus.ex_wdata_i : op_wdata_q;

    lsu_store_align u_align (
        .addr_lo   (al_addr),
        .size      (al_size),
        .wdata     (al_wdata),
        .be        (al_be),
        .lane_data (al_lane),
        .misalign  (al_misalign)
    );

    always_comb begin
        ld_half = op_addr_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
        ld_byte = op_addr_q[0] ? ld_half[15:8] : ld_half[7:0];
        case (op_size_q)
            SZ_B:    ld_data = op_uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = op_uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = bus.data_rdata_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Down-counter loaded on entry to REQ; reaching zero means TIMEOUT_CYCLES cycles spent on the bus.
    assign tmo_hit = (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (idle && state_d == REQ) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == REQ || state_q == WAIT) && !tmo_hit) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        op_size_d   = op_size_q;
        op_uns_d    = op_uns_q;
        op_rd_d     = op_rd_q;
        res_data_d  = res_data_q;
        res_exc_d   = res_exc_q;
        res_cause_d = res_cause_q;
        case (state_q)
            IDLE: begin
                if (bus.ex_valid_i) begin
                    op_we_d     = bus.ex_we_i;
                    op_addr_d   = bus.ex_addr_i;
                    op_wdata_d  = bus.ex_wdata_i;
                    op_size_d   = decode_size(bus.ex_size_i);
                    op_uns_d    = bus.ex_unsigned_i;
                    op_rd_d     = bus.ex_rd_i;
                    res_data_d  = '0;
                    res_exc_d   = 1'b0;
                    res_cause_d = '0;
                    if (al_misalign) begin
                        state_d     = RESP;
                        res_exc_d   = 1'b1;
                        res_cause_d = bus.ex_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                    end else begin
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.data_gnt_i) begin
                    state_d = WAIT;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    res_exc_d   = 1'b1;
                    res_cause_d = op_we_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                end
            end
            WAIT: begin
                if (bus.data_rvalid_i) begin
                    state_d = RESP;
                    if (bus.data_err_i) begin
                        res_exc_d   = 1'b1;
                        res_cause_d = op_we_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                    end else begin
                        res_data_d  = op_we_q ? 32'h0 : ld_data;
                    end
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    res_exc_d   = 1'b1;
                    res_cause_d = op_we_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_we_q     <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            op_size_q   <= SZ_B;
            op_uns_q    <= 1'b0;
            op_rd_q     <= '0;
            res_data_q  <= '0;
            res_exc_q   <= 1'b0;
            res_cause_q <= '0;
        end else begin
            state_q     <= state_d;
            op_we_q     <= op_we_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            op_size_q   <= op_size_d;
            op_uns_q    <= op_uns_d;
            op_rd_q     <= op_rd_d;
            res_data_q  <= res_data_d;
            res_exc_q   <= res_exc_d;
            res_cause_q <= res_cause_d;
        end
    end

    assign bus.ex_ready_o   = idle;
    assign bus.busy_o       = !idle;
    assign bus.data_req_o   = (state_q == REQ);
    assign bus.data_we_o    = bus.data_req_o & op_we_q;
    assign bus.data_addr_o  = bus.data_req_o ? {op_addr_q[31:2], 2'b00} : 32'h0;
    assign bus.data_be_o    = bus.data_req_o ? al_be : 4'h0;
    assign bus.data_wdata_o = bus.data_we_o ? al_lane : 32'h0;

    assign bus.wb_valid_o   = (state_q == RESP) & !res_exc_q;
    assign bus.wb_we_o      = bus.wb_valid_o & !op_we_q;
    assign bus.wb_rd_o      = bus.wb_valid_o ? op_rd_q : 5'h0;
    assign bus.wb_data_o    = bus.wb_valid_o ? res_data_q : 32'h0;
    assign bus.exc_valid_o  = (state_q == RESP) & res_exc_q;
    assign bus.exc_cause_o  = bus.exc_valid_o ? res_cause_q : 4'h0;
    assign bus.exc_tval_o   = bus.exc_valid_o ? op_addr_q : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against an arithmetic reference of the access rules.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if bus();

`ifdef LSU_TIMEOUT_EN
    lsu_ctrl #(.TIMEOUT_CYCLES(8)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`else
    lsu_ctrl u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic scramble_ex();
        bus.ex_we_i       = 1'($urandom);
        bus.ex_addr_i     = $urandom;
        bus.ex_wdata_i    = $urandom;
        bus.ex_size_i     = 2'($urandom);
        bus.ex_unsigned_i = 1'($urandom);
        bus.ex_rd_i       = 5'($urandom);
    endtask

    task automatic offer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd);
        bus.ex_valid_i    = 1'b1;
        bus.ex_we_i       = we;
        bus.ex_addr_i     = addr;
        bus.ex_wdata_i    = wdata;
        bus.ex_size_i     = size;
        bus.ex_unsigned_i = uns;
        bus.ex_rd_i       = rd;
    endtask

    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic err, input logic noise);
        int          nb;
        int          lane;
        logic        mis;
        logic [31:0] mask;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        nb     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis    = (addr % nb) != 0;
        lane   = int'(addr % 4) - int'((addr % 4) % nb);
        exp_be = ((32'h1 << nb) - 1) << lane;
        mask   = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
        exp_wd = !we ? 32'h0 : (nb == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (nb == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        exp_ld = (rdata >> (8 * lane)) & mask;
        if (!uns && nb < 4 && exp_ld[8 * nb - 1]) exp_ld = exp_ld | ~mask;

        @(negedge clk);
        chk("idle ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk("idle no pulse", 32'(bus.wb_valid_o | bus.exc_valid_o), 32'd0);
        offer(we, addr, wdata, size, uns, rd);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        scramble_ex();
        if (mis) begin
            chk("mis req", 32'(bus.data_req_o), 32'd0);
            chk("mis exc_valid", 32'(bus.exc_valid_o), 32'd1);
            chk("mis cause", 32'(bus.exc_cause_o), we ? 32'd6 : 32'd4);
            chk("mis tval", bus.exc_tval_o, addr);
            chk("mis wb_valid", 32'(bus.wb_valid_o), 32'd0);
            chk("mis ex_ready", 32'(bus.ex_ready_o), 32'd0);
        end else begin
            for (int k = 0; k <= gnt_dly; k++) begin
                chk("req", 32'(bus.data_req_o), 32'd1);
                chk("req we", 32'(bus.data_we_o), 32'(we));
                chk("req addr", bus.data_addr_o, addr & 32'hFFFF_FFFC);
                chk("req be", 32'(bus.data_be_o), exp_be);
                chk("req wdata", bus.data_wdata_o, exp_wd);
                chk("req ex_ready", 32'(bus.ex_ready_o), 32'd0);
                bus.data_gnt_i    = (k == gnt_dly);
                bus.data_rvalid_i = noise & 1'($urandom);
                bus.data_err_i    = 1'($urandom);
                bus.data_rdata_i  = $urandom;
                @(negedge clk);
            end
            bus.data_gnt_i    = 1'b0;
            bus.data_rvalid_i = 1'b0;
            bus.data_err_i    = 1'b0;
            for (int j = 0; j <= rv_dly; j++) begin
                chk("wait req", 32'(bus.data_req_o), 32'd0);
                chk("wait no pulse", 32'(bus.wb_valid_o | bus.exc_valid_o), 32'd0);
                if (j == rv_dly) begin
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i  = rdata;
                    bus.data_err_i    = err;
                end
                @(negedge clk);
            end
            bus.data_rvalid_i = 1'b0;
            bus.data_err_i    = 1'b0;
            bus.data_rdata_i  = $urandom;
            chk("resp ex_ready", 32'(bus.ex_ready_o), 32'd0);
            chk("resp busy", 32'(bus.busy_o), 32'd1);
            if (err) begin
                chk("fault exc_valid", 32'(bus.exc_valid_o), 32'd1);
                chk("fault cause", 32'(bus.exc_cause_o), we ? 32'd7 : 32'd5);
                chk("fault tval", bus.exc_tval_o, addr);
                chk("fault wb_valid", 32'(bus.wb_valid_o), 32'd0);
            end else begin
                chk("wb_valid", 32'(bus.wb_valid_o), 32'd1);
                chk("wb_we", 32'(bus.wb_we_o), 32'(!we));
                chk("wb_rd", 32'(bus.wb_rd_o), 32'(rd));
                chk("wb_data", bus.wb_data_o, we ? 32'h0 : exp_ld);
                chk("wb exc_valid", 32'(bus.exc_valid_o), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_valid_i    = 1'b0;
        bus.ex_we_i       = 1'b0;
        bus.ex_addr_i     = '0;
        bus.ex_wdata_i    = '0;
        bus.ex_size_i     = '0;
        bus.ex_unsigned_i = 1'b0;
        bus.ex_rd_i       = '0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = '0;
        bus.data_err_i    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk("rst req", 32'(bus.data_req_o), 32'd0);
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk("rst exc_valid", 32'(bus.exc_valid_o), 32'd0);
        chk("rst wb_data", bus.wb_data_o, 32'h0);
        chk("rst addr", bus.data_addr_o, 32'h0);
        rst = 1'b0;

        // Directed cases from the access rules
        run_op(1'b1, 32'h1003, 32'h0000_00AB, 2'd0, 1'b0, 5'd1, 0, 0, 32'h0, 1'b0, 1'b0);
        run_op(1'b0, 32'h2002, 32'h0, 2'd1, 1'b0, 5'd2, 0, 0, 32'h8001_1234, 1'b0, 1'b0);
        run_op(1'b0, 32'h2002, 32'h0, 2'd1, 1'b1, 5'd3, 0, 0, 32'h8001_1234, 1'b0, 1'b0);
        run_op(1'b0, 32'h2001, 32'h0, 2'd0, 1'b0, 5'd4, 0, 0, 32'h0000_F500, 1'b0, 1'b0);
        run_op(1'b0, 32'h3002, 32'h0, 2'd2, 1'b0, 5'd5, 0, 0, 32'h0, 1'b0, 1'b0);
        run_op(1'b1, 32'h4000, 32'hDEAD_BEEF, 2'd2, 1'b0, 5'd6, 5, 0, 32'h0, 1'b1, 1'b1);
        run_op(1'b0, 32'h2203, 32'h0, 2'd3, 1'b0, 5'd7, 0, 1, 32'h1234_5678, 1'b0, 1'b0);

        // Reset while waiting for the response; the late response must vanish
        @(negedge clk);
        offer(1'b0, 32'h5000, 32'h0, 2'd2, 1'b0, 5'd9);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        bus.data_gnt_i = 1'b0;
        chk("pre-rst busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        chk("late rv wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk("late rv exc_valid", 32'(bus.exc_valid_o), 32'd0);
        chk("late rv ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk("late rv busy", 32'(bus.busy_o), 32'd0);
        chk("late rv req", 32'(bus.data_req_o), 32'd0);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        offer(1'b0, 32'h6000, 32'h0, 2'd2, 1'b0, 5'd10);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("tmo req held", 32'(bus.data_req_o), 32'd1);
            @(negedge clk);
        end
        chk("tmo req dropped", 32'(bus.data_req_o), 32'd0);
        chk("tmo exc_valid", 32'(bus.exc_valid_o), 32'd1);
        chk("tmo cause", 32'(bus.exc_cause_o), 32'd5);
        chk("tmo tval", bus.exc_tval_o, 32'h6000);
        @(negedge clk);
        bus.data_rvalid_i = 1'b1;
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        chk("tmo stale rv", 32'(bus.wb_valid_o | bus.exc_valid_o), 32'd0);
        chk("tmo stale ready", 32'(bus.ex_ready_o), 32'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 32'hFFFF));
            run_op(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), 5'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                   ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        @(negedge clk);
        chk("final ex_ready", 32'(bus.ex_ready_o), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
